// File: rtl/profir_pkg.sv
// Shared constants and FSM state type for the profir coefficient loader.
package profir_pkg;

  localparam int NUM_BANKS = 8;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 6;
  localparam int COEFF_W   = 36;

  localparam logic [3:0] CMD_NIB = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    DATA,
    WRITE,
    CSUM
  } state_t;

endpackage

// File: rtl/profir_coeff_ram.sv
// One coefficient bank: simple dual-port RAM with a registered read-first read port.
module profir_coeff_ram
  import profir_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COEFF_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COEFF_W-1:0] rdata
);

  logic [COEFF_W-1:0] mem [DEPTH];

  // Write port; the array itself is never reset so loaded words survive a reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to the same address returns the old word.
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/profir_coeff_loader.sv
// Framed byte-stream loader feeding eight coefficient banks read in parallel by the FIR engine.
module profir_coeff_loader
  import profir_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  coeffaddress,
  output logic [COEFF_W-1:0] coeff0,
  output logic [COEFF_W-1:0] coeff1,
  output logic [COEFF_W-1:0] coeff2,
  output logic [COEFF_W-1:0] coeff3,
  output logic [COEFF_W-1:0] coeff4,
  output logic [COEFF_W-1:0] coeff5,
  output logic [COEFF_W-1:0] coeff6,
  output logic [COEFF_W-1:0] coeff7,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err
);

  state_t             state, state_nxt;
  logic               started;
  logic [2:0]         bank;
  logic [ADDR_W-1:0]  waddr;
  logic [6:0]         remaining;
  logic [2:0]         byte_idx;
  logic [39:0]        asm_reg;
  logic [7:0]         csum;
  logic               done_nxt, err_nxt;
  logic               fire, hdr_ok;
  logic               unused_hi;
  logic [COEFF_W-1:0] rd [NUM_BANKS];

  assign fire      = rx_valid & rx_ready;
  assign hdr_ok    = (rx_data[7:4] == CMD_NIB) && !rx_data[3];
  assign rx_ready  = started && (state != WRITE);
  assign load_busy = (state != IDLE);
  assign unused_hi = ^asm_reg[39:36];

  // Holds rx_ready low for the first cycle after reset releases.
  always_ff @(posedge clock) begin
    if (reset) started <= 1'b0;
    else       started <= 1'b1;
  end

  // State register and the registered status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= done_nxt;
      load_err  <= err_nxt;
    end
  end

  // Frame parser: next state and which pulse, if any, the accepted byte produces.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (fire) begin
        if (hdr_ok) state_nxt = ADDR;
        else        err_nxt   = 1'b1;
      end
      ADDR: if (fire) begin
        if (rx_data[7:6] != 2'b00) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = CNT;
        end
      end
      CNT: if (fire) begin
        if (rx_data > 8'd64) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: if (fire && byte_idx == 3'd4) state_nxt = WRITE;
      WRITE: state_nxt = (remaining > 7'd1) ? DATA : CSUM;
      CSUM: if (fire) begin
        state_nxt = IDLE;
        if (rx_data == csum) done_nxt = 1'b1;
        else                 err_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latched bank, write address, word count, byte assembly and running XOR.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank      <= '0;
      waddr     <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      asm_reg   <= '0;
      csum      <= '0;
    end else begin
      case (state)
        IDLE: if (fire && hdr_ok) begin
          bank <= rx_data[2:0];
          csum <= rx_data;
        end
        ADDR: if (fire && rx_data[7:6] == 2'b00) begin
          waddr <= rx_data[5:0];
          csum  <= csum ^ rx_data;
        end
        CNT: if (fire) begin
          remaining <= (rx_data == 8'd0) ? 7'd64 : rx_data[6:0];
          byte_idx  <= '0;
          csum      <= csum ^ rx_data;
        end
        DATA: if (fire) begin
          asm_reg  <= {rx_data, asm_reg[39:8]};
          byte_idx <= byte_idx + 3'd1;
          csum     <= csum ^ rx_data;
        end
        WRITE: begin
          waddr     <= waddr + 6'd1;
          remaining <= remaining - 7'd1;
          byte_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    profir_coeff_ram u_ram (
      .clock (clock),
      .reset (reset),
      .we    ((state == WRITE) && (bank == 3'(g))),
      .waddr (waddr),
      .wdata (asm_reg[35:0]),
      .raddr (coeffaddress),
      .rdata (rd[g])
    );
  end

  assign coeff0 = rd[0];
  assign coeff1 = rd[1];
  assign coeff2 = rd[2];
  assign coeff3 = rd[3];
  assign coeff4 = rd[4];
  assign coeff5 = rd[5];
  assign coeff6 = rd[6];
  assign coeff7 = rd[7];

endmodule

// File: tb/tb_profir_coeff_loader.sv
// Scoreboard bench for profir_coeff_loader: frames go in, pulses and read data are checked by a monitor.
module tb_profir_coeff_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [5:0]  coeffaddress;
  logic [35:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic        load_busy, load_done, load_err;

  profir_coeff_loader dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .coeffaddress (coeffaddress),
    .coeff0       (coeff0),
    .coeff1       (coeff1),
    .coeff2       (coeff2),
    .coeff3       (coeff3),
    .coeff4       (coeff4),
    .coeff5       (coeff5),
    .coeff6       (coeff6),
    .coeff7       (coeff7),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clock = ~clock;

  logic [35:0] coeff_arr [8];
  assign coeff_arr[0] = coeff0;
  assign coeff_arr[1] = coeff1;
  assign coeff_arr[2] = coeff2;
  assign coeff_arr[3] = coeff3;
  assign coeff_arr[4] = coeff4;
  assign coeff_arr[5] = coeff5;
  assign coeff_arr[6] = coeff6;
  assign coeff_arr[7] = coeff7;

  typedef struct packed {
    logic [7:0]     mask;
    logic [287:0]   val;
  } rd_exp_t;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  ev_q [$];
  rd_exp_t     rd_q [$];
  logic        rd_req = 1'b0;
  logic        rd_cap = 1'b0;
  logic [35:0] model [8][64];
  bit          known [8][64];
  logic [35:0] frame_words [64];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one byte from a negedge; returns at the negedge after it transferred.
  task automatic applyStimulus(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL rx_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pushRead(input logic [5:0] a);
    rd_exp_t e;
    e = '0;
    for (int b = 0; b < 8; b++) begin
      e.val[b*36 +: 36] = model[b][a];
      e.mask[b]         = known[b][a];
    end
    rd_q.push_back(e);
  endtask

  task automatic readCheck(input logic [5:0] a);
    coeffaddress = a;
    pushRead(a);
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
  endtask

  // Sends a whole frame from frame_words; probe selects a word whose write cycle is read-checked.
  task automatic sendFrame(input logic [2:0] bank, input logic [5:0] start, input int cnt,
                           input bit corrupt, input int probe);
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [35:0] wd;
    logic [5:0]  a;
    csum = 8'h00;
    b = {4'hA, 1'b0, bank};
    applyStimulus(b);
    csum ^= b;
    checkOutput("busy_after_hdr", {63'd0, load_busy}, 64'd1);
    b = {2'b00, start};
    applyStimulus(b);
    csum ^= b;
    b = (cnt == 64) ? 8'd0 : 8'(cnt);
    applyStimulus(b);
    csum ^= b;
    for (int i = 0; i < cnt; i++) begin
      wd = frame_words[i];
      for (int k = 0; k < 5; k++) begin
        if (k < 4) b = wd[8*k +: 8];
        else       b = {4'($urandom_range(15)), wd[35:32]};
        if ($urandom_range(3) == 0) @(negedge clock);
        applyStimulus(b);
        csum ^= b;
      end
      a = 6'((int'(start) + i) % 64);
      if (i == probe) begin
        coeffaddress = a;
        pushRead(a);
        rd_req = 1'b1;
        @(negedge clock);
        model[bank][a] = wd;
        known[bank][a] = 1'b1;
        pushRead(a);
        @(negedge clock);
        rd_req = 1'b0;
      end else begin
        model[bank][a] = wd;
        known[bank][a] = 1'b1;
      end
    end
    ev_q.push_back(corrupt ? EV_ERR : EV_DONE);
    applyStimulus(csum ^ (corrupt ? 8'h01 : 8'h00));
    checkOutput("busy_after_csum", {63'd0, load_busy}, 64'd0);
  endtask

  // Capture read requests on the sampling edge so the monitor knows when data is due.
  always @(posedge clock) rd_cap = rd_req;

  // Monitor: pops expectations whenever the DUT presents a pulse or a requested read.
  always @(negedge clock) begin
    rd_exp_t e;
    logic [1:0] ev;
    if (load_done || load_err) begin
      if (ev_q.size() == 0) begin
        checkOutput("unexpected_pulse", {62'd0, load_done, load_err}, 64'd0);
      end else begin
        ev = ev_q.pop_front();
        checkOutput("pulse", {62'd0, load_done, load_err}, {62'd0, ev});
      end
    end
    if (rd_cap) begin
      if (rd_q.size() == 0) begin
        checkOutput("read_queue_empty", 64'd1, 64'd0);
      end else begin
        e = rd_q.pop_front();
        for (int b = 0; b < 8; b++) begin
          if (e.mask[b]) checkOutput($sformatf("coeff%0d", b), {28'd0, coeff_arr[b]}, {28'd0, e.val[b*36 +: 36]});
        end
      end
    end
  end

  initial begin
    logic [2:0] rbank;
    logic [5:0] rstart;
    int         rcnt;
    bit         rcor;

    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 64; a++) begin
        known[b][a] = 1'b0;
        model[b][a] = '0;
      end
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    coeffaddress = 6'd0;

    // Reset state
    repeat (3) @(negedge clock);
    for (int b = 0; b < 8; b++) checkOutput($sformatf("reset_coeff%0d", b), {28'd0, coeff_arr[b]}, 64'd0);
    checkOutput("reset_rx_ready", {63'd0, rx_ready}, 64'd0);
    checkOutput("reset_busy", {63'd0, load_busy}, 64'd0);
    checkOutput("reset_pulses", {62'd0, load_done, load_err}, 64'd0);
    reset = 1'b0;
    #1 checkOutput("rx_ready_first_cycle", {63'd0, rx_ready}, 64'd0);
    @(negedge clock);
    checkOutput("rx_ready_after", {63'd0, rx_ready}, 64'd1);

    // Directed frame on bank 3
    frame_words[0] = 36'h123456789;
    frame_words[1] = 36'hFFFFFFFFF;
    sendFrame(3'd3, 6'd5, 2, 1'b0, -1);
    readCheck(6'd5);
    readCheck(6'd6);

    // Wrap from address 63 to 0 on bank 0
    frame_words[0] = 36'hA5A5A5A5A;
    frame_words[1] = 36'h00000C0DE;
    sendFrame(3'd0, 6'h3F, 2, 1'b0, -1);
    readCheck(6'd63);
    readCheck(6'd0);

    // Bad checksum still leaves the words written
    frame_words[0] = 36'h123456789;
    frame_words[1] = 36'hFFFFFFFFF;
    sendFrame(3'd3, 6'd5, 2, 1'b1, -1);
    frame_words[0] = 36'h876543210;
    frame_words[1] = 36'h0F0F0F0F0;
    sendFrame(3'd3, 6'd5, 2, 1'b1, -1);
    readCheck(6'd5);
    readCheck(6'd6);

    // Bad headers and a bad address byte are discarded with one error each
    ev_q.push_back(EV_ERR);
    applyStimulus(8'h55);
    ev_q.push_back(EV_ERR);
    applyStimulus(8'hA8);
    applyStimulus(8'hA2);
    ev_q.push_back(EV_ERR);
    applyStimulus(8'h45);
    frame_words[0] = 36'h314159265;
    sendFrame(3'd2, 6'd10, 1, 1'b0, -1);
    readCheck(6'd10);

    // Reset after the third data byte: no pulses, nothing written
    applyStimulus(8'hA4);
    applyStimulus(8'h20);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_busy", {63'd0, load_busy}, 64'd0);
    checkOutput("midreset_rx_ready", {63'd0, rx_ready}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    frame_words[0] = 36'h271828182;
    sendFrame(3'd4, 6'd32, 1, 1'b0, -1);
    readCheck(6'd32);

    // Read-first during the write cycle of an already-known address
    frame_words[0] = 36'hDEADBEEF1;
    frame_words[1] = 36'h0CAFE0042;
    sendFrame(3'd3, 6'd5, 2, 1'b0, 0);
    readCheck(6'd6);

    // Full 64-word frame (CNT byte 0) on bank 7
    for (int i = 0; i < 64; i++) frame_words[i] = {4'($urandom_range(15)), 32'($urandom)};
    sendFrame(3'd7, 6'd17, 64, 1'b0, -1);
    readCheck(6'd17);
    readCheck(6'd16);
    readCheck(6'd63);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      rbank  = 3'($urandom_range(7));
      rstart = 6'($urandom_range(63));
      rcnt   = int'($urandom_range(1, 6));
      rcor   = ($urandom_range(3) == 0);
      for (int i = 0; i < rcnt; i++) frame_words[i] = {4'($urandom_range(15)), 32'($urandom)};
      sendFrame(rbank, rstart, rcnt, rcor, -1);
      for (int i = 0; i < rcnt; i++) readCheck(6'((int'(rstart) + i) % 64));
      readCheck(6'($urandom_range(63)));
    end

    repeat (5) @(negedge clock);
    checkOutput("events_drained", 64'(ev_q.size()), 64'd0);
    checkOutput("reads_drained", 64'(rd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
